cnt_sched: RTL and testbench

Round-robin scheduler that shares one CW-bit up-counter between N_REQ requesters, each asking for a timed interval of a programmed length. It sits in front of the counter datapath. It grants the counter to one requester at a time, runs the interval, and signals completion with a one-cycle done pulse. It is the sequencing layer the counter blocks in this codebase need when several clients must take turns using the counter.

---
 rtl/cnt_sched_pkg.sv | 24 ++
 rtl/cnt_sched_if.sv | 38 +++
 rtl/cnt_sched_rr_arbiter.sv | 34 +++
 rtl/cnt_sched.sv | 123 ++++++++++++
 tb/tb_cnt_sched.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cnt_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnt_sched_pkg
// Description : Shared types and constants for the cnt_sched counter scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package cnt_sched_pkg;

    localparam int c_DEF_N_REQ = 4;
    localparam int c_DEF_CW    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // LSB position of requester idx's LEN field in the packed LEN bus
    function automatic int len_lsb(input int idx, input int cw);
        return idx * cw;
    endfunction

endpackage : cnt_sched_pkg
`default_nettype wire

// File: rtl/cnt_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : cnt_sched_if
// Description : Request/grant bundle between requesters and the cnt_sched core.
// Revision    : 1.0 - initial release
// ============================================================================
interface cnt_sched_if
    import cnt_sched_pkg::*;
#(
    parameter int N_REQ = c_DEF_N_REQ,
    parameter int CW    = c_DEF_CW
);
    logic [N_REQ-1:0]    REQ;
    logic [N_REQ*CW-1:0] LEN;
    logic [N_REQ-1:0]    GNT;
    logic [N_REQ-1:0]    DONE;
    logic                BUSY;
    logic [CW-1:0]       Q;

    modport master (
        output REQ,
        output LEN,
        input  GNT,
        input  DONE,
        input  BUSY,
        input  Q
    );

    modport slave (
        input  REQ,
        input  LEN,
        output GNT,
        output DONE,
        output BUSY,
        output Q
    );
endinterface : cnt_sched_if
`default_nettype wire

// File: rtl/cnt_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick, searching upward from i_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [PW-1:0]    i_ptr,
    output logic      [N_REQ-1:0] o_gnt,
    output logic      [PW-1:0]    o_idx,
    output logic                  o_valid
);

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int k;
            k = (int'(i_ptr) + i) % N_REQ;
            if (!o_valid && i_req[k]) begin
                o_valid  = 1'b1;
                o_gnt[k] = 1'b1;
                o_idx    = PW'(k);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/cnt_sched.sv
`default_nettype none
// ============================================================================
// Module      : cnt_sched
// Description : Round-robin scheduler sharing one CW-bit up-counter among
//               N_REQ requesters. Define CNT_SCHED_ABORT_EN to let a dropped
//               request abort its running interval.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int N_REQ = c_DEF_N_REQ,
    parameter int CW    = c_DEF_CW
) (
    input  wire logic  CLK,
    input  wire logic  CDN,
    cnt_sched_if.slave bus
);

    localparam int c_PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           r_state;
    logic [c_PW-1:0]  r_ptr;
    logic [CW-1:0]    r_len;
    logic [CW-1:0]    r_q;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_done;
    logic             r_busy;

    logic [N_REQ-1:0] w_win;
    logic [c_PW-1:0]  w_idx;
    logic             w_valid;
    logic [CW-1:0]    w_len;
    logic [c_PW-1:0]  w_ptr_next;
    logic             w_abort;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (c_PW)
    ) u_arb (
        .i_req   (bus.REQ),
        .i_ptr   (r_ptr),
        .o_gnt   (w_win),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_len      = bus.LEN[len_lsb(int'(w_idx), CW) +: CW];
    assign w_ptr_next = (w_idx == c_PW'(N_REQ - 1)) ? '0 : w_idx + c_PW'(1);

`ifdef CNT_SCHED_ABORT_EN
    // r_gnt is one-hot while busy, so this picks out the owner's request bit
    assign w_abort = (r_state != IDLE) && !(|(bus.REQ & r_gnt));
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!CDN) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_len   <= '0;
            r_q     <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= '0;
            if (w_abort) begin
                r_state <= IDLE;
                r_q     <= '0;
                r_gnt   <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_q <= '0;
                        if (w_valid) begin
                            r_gnt  <= w_win;
                            r_len  <= w_len;
                            r_ptr  <= w_ptr_next;
                            r_busy <= 1'b1;
                            if (w_len == '0) begin
                                r_state <= FIN;
                                r_done  <= w_win;
                            end else begin
                                r_state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        // Hold the final count through FIN; the counter never wraps
                        if (r_q == r_len - CW'(1)) begin
                            r_state <= FIN;
                            r_done  <= r_gnt;
                        end else begin
                            r_q <= r_q + CW'(1);
                        end
                    end
                    FIN: begin
                        r_state <= IDLE;
                        r_q     <= '0;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_q     <= '0;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.GNT  = r_gnt;
    assign bus.DONE = r_done;
    assign bus.BUSY = r_busy;
    assign bus.Q    = r_q;

endmodule : cnt_sched
`default_nettype wire

// File: tb/tb_cnt_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnt_sched
// Description : Directed self-checking bench for cnt_sched (N_REQ=4, CW=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_sched;

    logic clk;
    logic cdn;
    int   n_chk;
    int   n_fail;

    cnt_sched_if #(.N_REQ(4), .CW(5)) bus ();

    cnt_sched #(
        .N_REQ (4),
        .CW    (5)
    ) dut (
        .CLK (clk),
        .CDN (cdn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] gnt, input logic [3:0] done,
                           input logic busy, input logic [4:0] q);
        chk({tag, ".gnt"},  32'(bus.GNT),  32'(gnt));
        chk({tag, ".done"}, 32'(bus.DONE), 32'(done));
        chk({tag, ".busy"}, 32'(bus.BUSY), 32'(busy));
        chk({tag, ".q"},    32'(bus.Q),    32'(q));
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        cdn     = 1'b0;
        bus.REQ = '0;
        bus.LEN = '0;

        // Reset state
        tick();
        tick();
        chk_all("reset", 4'b0000, 4'b0000, 1'b0, 5'd0);
        cdn = 1'b1;
        tick();
        chk_all("idle", 4'b0000, 4'b0000, 1'b0, 5'd0);

        // Single request, LEN=3; LEN changed after grant must not matter
        bus.REQ       = 4'b0010;
        bus.LEN[5+:5] = 5'd3;
        tick();
        chk_all("t1.e1", 4'b0010, 4'b0000, 1'b1, 5'd0);
        bus.LEN[5+:5] = 5'd0;
        tick();
        chk_all("t1.e2", 4'b0010, 4'b0000, 1'b1, 5'd1);
        tick();
        chk_all("t1.e3", 4'b0010, 4'b0000, 1'b1, 5'd2);
        tick();
        chk_all("t1.e4", 4'b0010, 4'b0010, 1'b1, 5'd2);
        bus.REQ = 4'b0000;
        tick();
        chk_all("t1.e5", 4'b0000, 4'b0000, 1'b0, 5'd0);

        // Reset so the pointer restarts at 0, then all four requesting, LEN=2 each
        cdn = 1'b0;
        tick();
        cdn     = 1'b1;
        bus.REQ = 4'b1111;
        bus.LEN = {5'd2, 5'd2, 5'd2, 5'd2};
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_g;
            exp_g = 4'(1 << (k % 4));
            tick();
            chk_all($sformatf("t2.g%0d", k), exp_g, 4'b0000, 1'b1, 5'd0);
            tick();
            chk($sformatf("t2.q%0d", k), 32'(bus.Q), 32'd1);
            tick();
            chk_all($sformatf("t2.d%0d", k), exp_g, exp_g, 1'b1, 5'd1);
            tick();
            chk($sformatf("t2.i%0d", k), 32'(bus.BUSY), 32'd0);
        end
        bus.REQ = 4'b0000;
        tick();
        chk("t2.quiet", 32'(bus.BUSY), 32'd0);

        // LEN=0: grant and done in the same single cycle
        bus.REQ        = 4'b0100;
        bus.LEN[10+:5] = 5'd0;
        tick();
        chk_all("t3.e1", 4'b0100, 4'b0100, 1'b1, 5'd0);
        bus.REQ = 4'b0000;
        tick();
        chk_all("t3.e2", 4'b0000, 4'b0000, 1'b0, 5'd0);

        // LEN=31: count to 30, no wrap
        bus.REQ       = 4'b0001;
        bus.LEN[0+:5] = 5'd31;
        for (int e = 1; e <= 31; e++) begin
            tick();
            chk($sformatf("t4.q%0d", e), 32'(bus.Q), 32'(e - 1));
            chk($sformatf("t4.d%0d", e), 32'(bus.DONE), 32'd0);
        end
        tick();
        chk_all("t4.e32", 4'b0001, 4'b0001, 1'b1, 5'd30);
        bus.REQ = 4'b0000;
        tick();
        chk_all("t4.e33", 4'b0000, 4'b0000, 1'b0, 5'd0);

        // REQ[3] dropped at Q=1 of a LEN=5 run
        bus.REQ        = 4'b1000;
        bus.LEN[15+:5] = 5'd5;
        tick();
        chk_all("t5.e1", 4'b1000, 4'b0000, 1'b1, 5'd0);
        tick();
        chk_all("t5.e2", 4'b1000, 4'b0000, 1'b1, 5'd1);
        bus.REQ = 4'b0000;
`ifdef CNT_SCHED_ABORT_EN
        tick();
        chk_all("t5.abort", 4'b0000, 4'b0000, 1'b0, 5'd0);
        for (int e = 4; e <= 7; e++) begin
            tick();
            chk($sformatf("t5.nodone%0d", e), 32'(bus.DONE), 32'd0);
        end
`else
        for (int e = 3; e <= 5; e++) begin
            tick();
            chk_all($sformatf("t5.e%0d", e), 4'b1000, 4'b0000, 1'b1, 5'(e - 1));
        end
        tick();
        chk_all("t5.e6", 4'b1000, 4'b1000, 1'b1, 5'd4);
        tick();
        chk_all("t5.e7", 4'b0000, 4'b0000, 1'b0, 5'd0);
`endif

        // Reset mid-run at Q=2, then pointer must restart at requester 0
        bus.REQ       = 4'b0010;
        bus.LEN[5+:5] = 5'd5;
        tick();
        chk_all("t6.e1", 4'b0010, 4'b0000, 1'b1, 5'd0);
        tick();
        tick();
        chk("t6.q2", 32'(bus.Q), 32'd2);
        cdn = 1'b0;
        tick();
        chk_all("t6.rst", 4'b0000, 4'b0000, 1'b0, 5'd0);
        cdn     = 1'b1;
        bus.REQ = 4'b1111;
        bus.LEN = {5'd3, 5'd3, 5'd3, 5'd3};
        tick();
        chk_all("t6.regrant", 4'b0001, 4'b0000, 1'b1, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_cnt_sched
`default_nettype wire
